if_prefetch: RTL and testbench

Parametrised instruction-fetch stage with a prefetch queue, succeeding the single-register PC fetch stage. It drives a 1-cycle-latency instruction memory and buffers fetched words plus their PC in a DEPTH-entry FIFO. Decode takes instructions over a valid/ready handshake. It supports absolute or PC-relative branch redirect with flush of queued and in-flight fetches.

---
 rtl/if_pkg.sv | 30 +++
 rtl/if_prefetch_fifo.sv | 58 +++++
 rtl/if_prefetch.sv | 108 ++++++++++
 tb/tb_if_prefetch.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and helpers for the instruction-fetch prefetch stage.
package if_pkg;

   // Datapath widths the FIFO entry is built from; the top defaults to these.
   localparam int IF_XLEN = 16;
   localparam int IF_ILEN = 16;

   // Byte distance between consecutive instructions.
   localparam int PC_STEP = IF_ILEN / 8;

   // One prefetched instruction together with the PC it was fetched from.
   typedef struct packed {
      logic [IF_ILEN-1:0] inst;
      logic [IF_XLEN-1:0] pc;
   } fetch_entry_t;

   // Sign-extend the low val_w bits of val to IF_XLEN, then scale by 2**shift.
   function automatic logic [IF_XLEN-1:0] sext_shift(input logic [IF_XLEN-1:0] val,
                                                     input int val_w,
                                                     input int shift);
      logic [IF_XLEN-1:0] mask;
      logic               sign;
      logic [IF_XLEN-1:0] ext;
      mask = '1 << val_w;
      sign = |((val >> (val_w - 1)) & IF_XLEN'(1));
      ext  = (val & ~mask) | ({IF_XLEN{sign}} & mask);
      return ext << shift;
   endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; DEPTH must be a power of two.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   // Storage write.
   // NOTE: the data array has no reset; the pointers and count alone define
   // which words are meaningful, so clearing storage would only cost logic.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointer and occupancy update; reset and flush both empty the queue.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch stage: issues reads to a 1-cycle memory, buffers
// {instruction, pc} in a prefetch FIFO and hands them to decode over
// valid/ready. Redirects flush the queue and squash the outstanding read.
// XLEN/ILEN must match the entry widths defined in if_pkg.
module if_prefetch
   import if_pkg::*;
#(
   parameter int               XLEN     = IF_XLEN,
   parameter int               ILEN     = IF_ILEN,
   parameter int               DEPTH    = 4,
   parameter int               BR_W     = 8,
   parameter int               BR_REL   = 1,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            br_taken,
   input  logic [BR_W-1:0] br_val,
   input  logic [XLEN-1:0] br_base,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [ILEN-1:0] imem_rdata,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [ILEN-1:0] inst_out,
   output logic [XLEN-1:0] inst_pc,
   output logic [XLEN-1:0] inst_pcn
);

   localparam int              CNT_W    = $clog2(DEPTH) + 1;
   localparam int              BR_SHIFT = $clog2(PC_STEP);
   localparam logic [XLEN-1:0] STEP     = XLEN'(PC_STEP);

   logic [XLEN-1:0]  fetch_pc;
   logic [XLEN-1:0]  req_pc;
   logic             inflight;
   logic             drop;
   logic [CNT_W-1:0] count;
   logic [CNT_W:0]   used;
   logic             empty;
   logic             issue;
   logic             push;
   logic             pop;
   logic [XLEN-1:0]  br_target;
   fetch_entry_t     wr_entry;
   fetch_entry_t     rd_entry;

   // Credit check counts the outstanding read but not a same-cycle pop.
   assign used  = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
   assign issue = en & ~br_taken & ~rst & (used < (CNT_W+1)'(DEPTH));

   assign br_target = (BR_REL != 0)
                    ? br_base + sext_shift(XLEN'(br_val), BR_W, BR_SHIFT)
                    : XLEN'(br_val);

   assign imem_req  = issue;
   assign imem_addr = fetch_pc;

   assign push = imem_rvalid & inflight & ~drop & ~br_taken;
   assign pop  = inst_valid & inst_ready & ~br_taken;

   assign wr_entry   = '{inst: imem_rdata, pc: req_pc};
   assign inst_valid = ~empty & ~rst;
   assign inst_out   = rd_entry.inst;
   assign inst_pc    = rd_entry.pc;
   assign inst_pcn   = rd_entry.pc + STEP;

   // Fetch PC, outstanding-read tracking and redirect squash.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         req_pc   <= RESET_PC;
         inflight <= 1'b0;
         drop     <= 1'b0;
      end else begin
         if (br_taken)   fetch_pc <= br_target;
         else if (issue) fetch_pc <= fetch_pc + STEP;

         if (issue) req_pc <= fetch_pc;

         if (issue)            inflight <= 1'b1;
         else if (imem_rvalid) inflight <= 1'b0;

         // A read answered in the redirect cycle is squashed via push; only a
         // read still outstanding afterwards needs the drop marker.
         if (br_taken)         drop <= inflight & ~imem_rvalid;
         else if (imem_rvalid) drop <= 1'b0;
      end
   end

   sync_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (br_taken),
      .push  (push),
      .wdata (wr_entry),
      .pop   (pop),
      .rdata (rd_entry),
      .count (count),
      .empty (empty)
   );

endmodule

// File: tb/tb_if_prefetch.sv
// Scoreboard bench for if_prefetch: the stimulus pushes expected PCs, a
// monitor compares every accepted instruction against the queue head.
module tb_if_prefetch;

   logic        clk = 1'b0;
   logic        rst, en, br_taken, inst_ready;
   logic [7:0]  br_val;
   logic [15:0] br_base;

   // Main DUT (BR_REL=1, RESET_PC=0).
   logic        imem_req, imem_rvalid, inst_valid;
   logic [15:0] imem_addr, imem_rdata, inst_out, inst_pc, inst_pcn;

   // Absolute-branch DUT.
   logic        br1;
   logic [7:0]  bv1;
   logic        req1, rv1, val1;
   logic [15:0] addr1, rd1, out1, pc1, pcn1;

   // Wrapping reset-PC DUT.
   logic        req2, rv2, val2;
   logic [15:0] addr2, rd2, out2, pc2, pcn2;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   if_prefetch u_dut (
      .clk(clk), .rst(rst), .en(en), .br_taken(br_taken), .br_val(br_val),
      .br_base(br_base), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out),
      .inst_pc(inst_pc), .inst_pcn(inst_pcn)
   );

   if_prefetch #(.BR_REL(0)) u_abs (
      .clk(clk), .rst(rst), .en(en), .br_taken(br1), .br_val(bv1),
      .br_base(16'h1234), .imem_req(req1), .imem_addr(addr1),
      .imem_rvalid(rv1), .imem_rdata(rd1),
      .inst_valid(val1), .inst_ready(1'b0), .inst_out(out1),
      .inst_pc(pc1), .inst_pcn(pcn1)
   );

   if_prefetch #(.RESET_PC(16'hFFFE)) u_wrap (
      .clk(clk), .rst(rst), .en(en), .br_taken(1'b0), .br_val(8'h00),
      .br_base(16'h0000), .imem_req(req2), .imem_addr(addr2),
      .imem_rvalid(rv2), .imem_rdata(rd2),
      .inst_valid(val2), .inst_ready(1'b0), .inst_out(out2),
      .inst_pc(pc2), .inst_pcn(pcn2)
   );

   // Memory models: one-cycle latency, returned word equals its address.
   always @(posedge clk) begin
      imem_rvalid <= imem_req;
      imem_rdata  <= imem_addr;
      rv1         <= req1;
      rd1         <= addr1;
      rv2         <= req2;
      rd2         <= addr2;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every accepted head must match the next expected entry.
   always @(negedge clk) begin
      if (!rst && inst_valid && inst_ready && !br_taken) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop: got pc %h expected no transfer", inst_pc);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            check("pop_pc",   32'(inst_pc),  32'(e));
            check("pop_inst", 32'(inst_out), 32'(e));
            check("pop_pcn",  32'(inst_pcn), 32'(e + 16'd2));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bounded wait for the scoreboard to empty, then confirm the FIFO drained.
   task automatic drain(input string tag);
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
      check({tag, "_all_delivered"}, 32'(exp_q.size()), 32'd0);
      tick();
      @(negedge clk);
      check({tag, "_drained"}, 32'(inst_valid), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      int reqs;
      rst = 1'b1; en = 1'b0; br_taken = 1'b0; inst_ready = 1'b0;
      br_val = '0; br_base = '0; br1 = 1'b0; bv1 = '0;

      // Streaming fetch from reset, then en dropped mid-stream.
      tick(); tick();
      @(negedge clk);
      check("rst_req",   32'(imem_req),   32'd0);
      check("rst_valid", 32'(inst_valid), 32'd0);
      for (int i = 0; i < 8; i++) exp_q.push_back(16'(2 * i));
      tick();
      rst = 1'b0; en = 1'b1; inst_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("p1_req",   32'(imem_req),   32'd1);
         check("p1_addr",  32'(imem_addr),  32'(2 * i));
         check("p1_valid", 32'(inst_valid), 32'(i >= 2));
         tick();
      end
      en = 1'b0;
      @(negedge clk);
      check("p1_en_off_req", 32'(imem_req), 32'd0);
      drain("p1");

      // Back-pressure: credits cap outstanding work at DEPTH.
      rst = 1'b1; en = 1'b1; inst_ready = 1'b0;
      tick(); tick();
      for (int i = 0; i < 5; i++) exp_q.push_back(16'(2 * i));
      rst = 1'b0;
      reqs = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (imem_req) reqs++;
         if (inst_valid) check("p2_hold_pc", 32'(inst_pc), 32'd0);
         tick();
      end
      check("p2_req_count", 32'(reqs), 32'd4);
      inst_ready = 1'b1;
      tick(); tick();
      en = 1'b0;
      drain("p2");

      // Reset while the FIFO holds three entries.
      rst = 1'b1; en = 1'b1; inst_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick(); tick(); tick();
      @(negedge clk);
      check("p3_pre_valid", 32'(inst_valid), 32'd1);
      tick();
      rst = 1'b1;
      @(negedge clk);
      check("p3_rst_valid", 32'(inst_valid), 32'd0);
      check("p3_rst_req",   32'(imem_req),   32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("p3_after_valid", 32'(inst_valid), 32'd0);
      check("p3_restart_req", 32'(imem_req),   32'd1);
      check("p3_restart_pc",  32'(imem_addr),  32'd0);

      // Relative redirect with a read being answered in the redirect cycle.
      rst = 1'b1; en = 1'b1; inst_ready = 1'b1;
      tick(); tick();
      exp_q.push_back(16'h0008);
      exp_q.push_back(16'h000A);
      rst = 1'b0;
      tick();
      tick();
      br_taken = 1'b1; br_base = 16'h0010; br_val = 8'hFC;
      @(negedge clk);
      check("p4_br_req", 32'(imem_req), 32'd0);
      tick();
      br_taken = 1'b0;
      @(negedge clk);
      check("p4_tgt_req",   32'(imem_req),   32'd1);
      check("p4_tgt_addr",  32'(imem_addr),  32'h0008);
      check("p4_flush_val", 32'(inst_valid), 32'd0);
      tick();
      @(negedge clk);
      check("p4_gap_valid", 32'(inst_valid), 32'd0);
      check("p4_next_addr", 32'(imem_addr),  32'h000A);
      tick();
      en = 1'b0;
      @(negedge clk);
      check("p4_tgt_valid", 32'(inst_valid), 32'd1);
      drain("p4");

      // Back-to-back redirects: the last target wins.
      en = 1'b1; br_taken = 1'b1; br_base = 16'h0010; br_val = 8'h04;
      exp_q.push_back(16'h0102);
      @(negedge clk);
      check("p5_br1_req", 32'(imem_req), 32'd0);
      tick();
      br_base = 16'h0100; br_val = 8'h01;
      @(negedge clk);
      check("p5_br2_req", 32'(imem_req), 32'd0);
      tick();
      br_taken = 1'b0;
      @(negedge clk);
      check("p5_req",  32'(imem_req),  32'd1);
      check("p5_addr", 32'(imem_addr), 32'h0102);
      tick();
      en = 1'b0;
      drain("p5");

      // Absolute redirect and PC wrap on the auxiliary instances.
      rst = 1'b1; en = 1'b1; inst_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      @(negedge clk);
      check("abs_first_addr",  32'(addr1), 32'h0000);
      check("wrap_first_addr", 32'(addr2), 32'hFFFE);
      tick();
      br1 = 1'b1; bv1 = 8'h40;
      @(negedge clk);
      check("abs_br_req",       32'(req1),  32'd0);
      check("wrap_second_req",  32'(req2),  32'd1);
      check("wrap_second_addr", 32'(addr2), 32'h0000);
      tick();
      br1 = 1'b0;
      @(negedge clk);
      check("abs_tgt_req",  32'(req1),  32'd1);
      check("abs_tgt_addr", 32'(addr1), 32'h0040);
      check("wrap_valid",   32'(val2),  32'd1);
      check("wrap_pc",      32'(pc2),   32'hFFFE);
      check("wrap_inst",    32'(out2),  32'hFFFE);
      check("wrap_pcn",     32'(pcn2),  32'h0000);
      tick();
      @(negedge clk);
      check("abs_gap_valid", 32'(val1), 32'd0);
      tick();
      @(negedge clk);
      check("abs_tgt_valid", 32'(val1), 32'd1);
      check("abs_tgt_pc",    32'(pc1),  32'h0040);

      en = 1'b0;
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
